// File: rtl/hilo_divide_unit_if.sv
// hilo_divide_unit_if: handshake and operand/result bundle for the HI/LO divider.
//   master : pipeline side. It drives start, signed_op, dividend and divisor.
//   slave  : divider side. It drives busy, stall, done, quotient, remainder
//            and div_by_zero.
interface hilo_divide_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, stall, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, stall, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/hilo_divide_unit.sv
// hilo_divide_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU in EX.
//   clk  : pipeline clock (rising edge)
//   rst  : synchronous, active-high reset
//   bus  : hilo_divide_unit_if.slave
//          start/signed_op/dividend/divisor in
//          busy/stall/done/quotient(LO)/remainder(HI)/div_by_zero out
// A normal divide takes WIDTH+1 edges from start to done.
// A divide by zero finishes after 1 edge: quotient is all ones and the
// remainder is the raw dividend.
// Macro DIV_SIGNED_EN: when it is defined, signed_op selects DIV. When it is
// undefined, every operation is unsigned and the sign logic is not built.
module hilo_divide_unit #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  hilo_divide_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] q_out, r_out;
  logic             dbz_out;

  logic             accept, dz, last;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_it, quo_it;
  logic [WIDTH-1:0] a_in, b_in, q_fin, r_fin;

  assign dz     = (bus.divisor == '0);
  assign accept = bus.start && (state != RUN);
  assign last   = (count == CW'(1));

  // One restoring step. The shifted remainder is WIDTH+1 bits wide, so the
  // compare cannot overflow. After the subtract the result is below the
  // divisor, so WIDTH bits are enough to store it.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvsr});
  assign rem_it = ge ? (rem_sh[WIDTH-1:0] - dvsr) : rem_sh[WIDTH-1:0];
  assign quo_it = {quo[WIDTH-2:0], ge};

`ifdef DIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa    = bus.signed_op & bus.dividend[WIDTH-1];
  assign sb    = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_in  = sa ? (-bus.dividend) : bus.dividend;
  assign b_in  = sb ? (-bus.divisor)  : bus.divisor;
  // Negation wraps modulo 2^WIDTH, so -2^(W-1)/-1 yields 2^(W-1) unflagged.
  assign q_fin = neg_q ? (-quo_it) : quo_it;
  assign r_fin = neg_r ? (-rem_it) : rem_it;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && !dz) begin
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.signed_op;
  assign a_in  = bus.dividend;
  assign b_in  = bus.divisor;
  assign q_fin = quo_it;
  assign r_fin = rem_it;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nx = dz ? DONE : RUN;
        else           state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. Operands are latched only when a start is accepted, so a start
  // that arrives during RUN leaves the running divide untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      q_out   <= '0;
      r_out   <= '0;
      dbz_out <= 1'b0;
    end else begin
      if (accept) begin
        if (dz) begin
          q_out   <= '1;
          r_out   <= bus.dividend;
          dbz_out <= 1'b1;
        end else begin
          rem   <= '0;
          quo   <= a_in;
          dvsr  <= b_in;
          count <= CW'(WIDTH);
        end
      end else if (state == RUN) begin
        rem   <= rem_it;
        quo   <= quo_it;
        count <= count - CW'(1);
        if (last) begin
          q_out   <= q_fin;
          r_out   <= r_fin;
          dbz_out <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.stall       = bus.busy | accept;
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dbz_out;
endmodule

// File: tb/tb_hilo_divide_unit.sv
module tb_hilo_divide_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  hilo_divide_unit_if #(.WIDTH(32)) bus ();

  hilo_divide_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Waits for done, sampling on the falling edge. lat counts falling edges
  // after the start edge. busy and stall must stay high until done appears.
  task automatic wait_done(output int lat, output bit win_ok);
    lat = -1;
    win_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) win_ok = 1'b0;
        return;
      end
      if (bus.busy !== 1'b1 || bus.stall !== 1'b1) win_ok = 1'b0;
    end
  endtask

  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_op = sg;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.stall} !== 4'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0)
      $display("FAIL reset_vals: busy=%b done=%b dbz=%b stall=%b q=%h r=%h want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.stall, bus.quotient, bus.remainder);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; bit ok;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    #1;
    total_cnt++;
    if (bus.stall !== 1'b1) $display("FAIL stall_on_start: got %b want 1", bus.stall);
    else pass_cnt++;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, ok);
    total_cnt++;
    if (lat !== 33) $display("FAIL udiv_latency: got %0d want 33", lat);
    else pass_cnt++;
    total_cnt++;
    if (!ok) $display("FAIL udiv_busy_window: busy/stall got gap want high until done");
    else pass_cnt++;
    total_cnt++;
    if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0)
      $display("FAIL udiv_100_7: got q=%0d r=%0d dbz=%b want 14 2 0", bus.quotient, bus.remainder, bus.div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.done !== 1'b0 || bus.quotient !== 32'd14)
      $display("FAIL done_pulse: got done=%b q=%0d want 0 14", bus.done, bus.quotient);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int lat; bit ok;
    logic [31:0] eq, er;
`ifdef DIV_SIGNED_EN
    eq = 32'hFFFFFFFD; er = 32'hFFFFFFFF;
`else
    eq = 32'h7FFFFFFC; er = 32'h00000001;
`endif
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, ok);
    total_cnt++;
    if (lat !== 33 || bus.quotient !== eq || bus.remainder !== er)
      $display("FAIL sdiv_m7_2: got lat=%0d q=%h r=%h want 33 %h %h", lat, bus.quotient, bus.remainder, eq, er);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat; bit ok;
    launch(1'b0, 32'd5, 32'd0);
    wait_done(lat, ok);
    total_cnt++;
    if (lat !== 1 || bus.busy !== 1'b0)
      $display("FAIL dz_latency: got lat=%0d busy=%b want 1 0", lat, bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.quotient !== 32'hFFFFFFFF || bus.remainder !== 32'd5 || bus.div_by_zero !== 1'b1)
      $display("FAIL dz_result: got q=%h r=%0d dbz=%b want ffffffff 5 1", bus.quotient, bus.remainder, bus.div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, dones; bit ok;
    launch(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0)
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total_cnt++;
    if (dones !== 0) $display("FAIL reset_no_done: got %0d done pulses want 0", dones);
    else pass_cnt++;
    launch(1'b0, 32'd9, 32'd3);
    wait_done(lat, ok);
    total_cnt++;
    if (lat !== 33 || bus.quotient !== 32'd3 || bus.remainder !== 32'd0)
      $display("FAIL after_reset_9_3: got lat=%0d q=%0d r=%0d want 33 3 0", lat, bus.quotient, bus.remainder);
    else pass_cnt++;
  endtask

  task automatic test_start_during_run();
    int lat; bit ok;
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, ok);
    total_cnt++;
    if (lat + 4 !== 33 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2)
      $display("FAIL start_in_run: got lat=%0d q=%0d r=%0d want 33 14 2", lat + 4, bus.quotient, bus.remainder);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, ok);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    #1;
    total_cnt++;
    if (bus.stall !== 1'b1 || bus.done !== 1'b1)
      $display("FAIL b2b_stall: got stall=%b done=%b want 1 1", bus.stall, bus.done);
    else pass_cnt++;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, ok);
    total_cnt++;
    if (lat !== 33 || !ok || bus.quotient !== 32'd10 || bus.remainder !== 32'd0)
      $display("FAIL b2b_50_5: got lat=%0d ok=%b q=%0d r=%0d want 33 1 10 0", lat, ok, bus.quotient, bus.remainder);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int lat; bit ok;
    logic [31:0] eq, er;
`ifdef DIV_SIGNED_EN
    eq = 32'h80000000; er = 32'h00000000;
`else
    eq = 32'h00000000; er = 32'h80000000;
`endif
    launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, ok);
    total_cnt++;
    if (lat !== 33 || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== 1'b0)
      $display("FAIL signed_ovf: got lat=%0d q=%h r=%h dbz=%b want 33 %h %h 0",
               lat, bus.quotient, bus.remainder, bus.div_by_zero, eq, er);
    else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_reset_mid();
    test_start_during_run();
    test_back_to_back();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/hilo_divide_unit.md
# hilo_divide_unit

Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
- Consumes rs/rt operands from the ID/EX register when a divide is in EX.
- Produces quotient (LO) and remainder (HI) for the HI/LO registers.
- Stalls the upstream pipeline while the operation runs.
- Latency is WIDTH+1 cycles; divide-by-zero finishes early.

## Interface
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.
- Clk  in  1  pipeline clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; clears all state and outputs.
- Start  in  1  request a divide; sampled only in IDLE or DONE.
- Signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- Dividend  in  WIDTH  rs operand.
- Divisor  in  WIDTH  rt operand.
- Busy  out  1  high while iterating (RUN state).
- Stall  out  1  combinational: Busy, or Start while in IDLE/DONE; holds IF/ID and ID/EX.
- Done  out  1  one-cycle pulse; results valid.
- Quotient  out  WIDTH  to LO; registered, held until the next Done.
- Remainder  out  WIDTH  to HI; registered, held until the next Done.
- DivByZero  out  1  registered with Done; high when Divisor was 0.

## Operation
States are IDLE, RUN and DONE.
- **IDLE/DONE + Start, Divisor≠0:**
  - Latch operands: magnitudes if signed and the sign bit is set, else raw.
  - Latch negQ = sign(Dividend)^sign(Divisor) and negR = sign(Dividend); both are 0 when unsigned.
  - Clear the partial remainder, load count = WIDTH, go to RUN.
- **IDLE/DONE + Start, Divisor==0:**
  - Go directly to DONE.
  - Quotient = all ones, Remainder = Dividend (raw), DivByZero = 1.
- **RUN, each cycle:**
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor magnitude, subtract it and set quo[0] = 1.
  - Decrement count; when count reaches 0, go to DONE.
- **RUN→DONE edge:**
  - Quotient = negQ ? −quo : quo.
  - Remainder = negR ? −rem : rem.
  - DivByZero = 0.
- **DONE:**
  - Done = 1 for exactly one cycle.
  - Next state is IDLE, or RUN/DONE if Start is present.
- **Arithmetic:**
  - Internal rem is WIDTH+1 bits, so the compare never overflows.
  - Negation is two's complement, modulo 2^WIDTH.
  - Signed −2^(WIDTH−1) / −1 gives Quotient 0x80000000 (wraps) and Remainder 0, with no flag.
- **Start while in RUN:** ignored; operands are not re-latched.
- **Reset in any state:** next state IDLE; Busy, Done, DivByZero, Quotient and Remainder are all 0; an in-flight result is discarded and produces no Done.

## Timing
- **Reset values:** Busy = 0, Done = 0, DivByZero = 0, Quotient = 0, Remainder = 0, state IDLE.
- **Normal divide:**
  - Start is sampled at edge E0, with Busy = 1 from E0.
  - Iterations occur at E1..E(WIDTH), and the last one moves the state to DONE.
  - Done = 1 in the cycle after E(WIDTH), i.e. Start-to-Done is WIDTH+1 edges (33 for WIDTH=32).
- **Divide-by-zero:** Done = 1 in the cycle after E0 (1 edge); Busy stays 0.
- **Stall:**
  - Rises combinationally with an accepted Start.
  - Stays high through RUN and falls in the Done cycle.
  - The EX instruction advances at the edge that ends the Done cycle.
- **Back-to-back:** Start during the Done cycle is accepted with no idle bubble.
- **Output timing:** outputs change only at the RUN→DONE edge, the divide-by-zero edge, or Reset.

## Configuration
- **DIV_SIGNED_EN defined:** Signed is honoured as described above.
- **DIV_SIGNED_EN undefined:**
  - Signed is ignored, and all operations are unsigned (negQ = negR = 0).
  - The magnitude and negation logic is not compiled in.

## Test plan
- **Unsigned 100 / 7:** Start, Signed = 0 → Done 33 cycles later; Quotient = 14, Remainder = 2, DivByZero = 0. Busy and Stall stay high for 32 cycles plus the Start cycle.
- **Signed −7 / 2 (0xFFFFFFF9 / 2):** Quotient = 0xFFFFFFFD, Remainder = 0xFFFFFFFF.
  - With DIV_SIGNED_EN undefined, the same inputs give Quotient = 0x7FFFFFFC, Remainder = 1.
- **5 / 0:** Done on the next cycle; Quotient = 0xFFFFFFFF, Remainder = 5, DivByZero = 1; Busy never rises.
- **Reset mid-operation:** Start 1000/3, assert Reset at cycle 10 → next cycle Busy = 0, Quotient = Remainder = 0, no Done pulse. A subsequent 9/3 gives Quotient = 3, Remainder = 0.
- **Start during RUN:** pulse Start with 50/5 while 100/7 is running → ignored; result is 14 rem 2.
- **Back-to-back:** Start 50/5 in the Done cycle → accepted; Done again 33 cycles later with Quotient = 10, Remainder = 0.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF signed → Quotient = 0x80000000, Remainder = 0.
